iter_alu: RTL and testbench

- Parametrised, multi-cycle successor to the CPU's combinational ALU.
- Executes the base logic, arithmetic and shift ops in one registered cycle.
- Adds iterative multiply, divide and remainder (RV32M-style) at one bit per cycle.
- Sits in the execute stage behind a valid/ready handshake; the pipeline stalls while in_ready is low.

---
 rtl/iter_alu.sv | 214 +++++++++++++++++++++
 tb/tb_iter_alu.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// iter_alu: execute-stage ALU with registered single-cycle ops and
// bit-serial multiply / divide / remainder behind a valid/ready handshake.
module iter_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_OR    = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_XOR   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_NOT   = 4'd5;
   localparam logic [3:0] OP_SLL   = 4'd6;
   localparam logic [3:0] OP_SRL   = 4'd7;
   localparam logic [3:0] OP_SRA   = 4'd8;
   localparam logic [3:0] OP_MUL   = 4'd9;
   localparam logic [3:0] OP_MULHU = 4'd10;
   localparam logic [3:0] OP_DIVU  = 4'd11;
   localparam logic [3:0] OP_REMU  = 4'd12;
   localparam logic [3:0] OP_DIV   = 4'd13;
   localparam logic [3:0] OP_REM   = 4'd14;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic             accept;
   logic             iter_op;
   logic             signed_div;
   logic             last_iter;
   logic [SHW-1:0]   count;
   logic [3:0]       op_r;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] mcand;
   logic             neg_q;
   logic             neg_r;
   logic             div_zero;

   logic [WIDTH-1:0] single_res;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] quo_next;
   logic [WIDTH-1:0] final_res;

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Handshake outputs and next state; a request taken while DONE chains directly.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !reset;
         end
         BUSY: begin
            in_ready = 1'b0;
         end
         DONE: begin
            in_ready  = !reset;
            out_valid = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
      accept = in_valid && in_ready;
      case (state)
         IDLE, DONE: begin
            if (accept) begin
               state_next = iter_op ? BUSY : DONE;
            end else begin
               state_next = IDLE;
            end
         end
         BUSY: begin
            if (last_iter) begin
               state_next = DONE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Single-cycle logic, arithmetic and shift results from the live operands.
   always_comb begin
      single_res = '0;
      case (op)
         OP_AND:  single_res = a & b;
         OP_OR:   single_res = a | b;
         OP_ADD:  single_res = a + b;
         OP_XOR:  single_res = a ^ b;
         OP_SUB:  single_res = a - b;
         OP_NOT:  single_res = ~a;
         OP_SLL:  single_res = a << b[SHW-1:0];
         OP_SRL:  single_res = a >> b[SHW-1:0];
         OP_SRA:  single_res = $unsigned($signed(a) >>> b[SHW-1:0]);
         default: single_res = '0;
      endcase
   end

   // Operand preparation: signed divides work on magnitudes and fix the sign at the end.
   always_comb begin
      iter_op    = (op >= OP_MUL) && (op <= OP_REM);
      signed_div = (op == OP_DIV) || (op == OP_REM);
      a_mag      = (signed_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
      b_mag      = (signed_div && b[WIDTH-1]) ? (~b + 1'b1) : b;
   end

   // One iteration: shift-add for multiply, restoring subtract for divide.
   always_comb begin
      mul_sum   = {1'b0, acc} + (quo[0] ? {1'b0, mcand} : '0);
      div_shift = {acc, quo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, mcand};
      acc_next  = '0;
      quo_next  = '0;
      if ((op_r == OP_MUL) || (op_r == OP_MULHU)) begin
         acc_next = mul_sum[WIDTH:1];
         quo_next = {mul_sum[0], quo[WIDTH-1:1]};
      end else if (!div_diff[WIDTH]) begin
         acc_next = div_diff[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         acc_next = div_shift[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
      last_iter = (state == BUSY) && (count == {SHW{1'b1}});
   end

   // Final selection and sign fix-up; signed divide by zero must stay all ones.
   always_comb begin
      final_res = '0;
      case (op_r)
         OP_MUL:   final_res = quo_next;
         OP_MULHU: final_res = acc_next;
         OP_DIVU:  final_res = quo_next;
         OP_REMU:  final_res = acc_next;
         OP_DIV:   final_res = div_zero ? '1 : (neg_q ? (~quo_next + 1'b1) : quo_next);
         OP_REM:   final_res = neg_r ? (~acc_next + 1'b1) : acc_next;
         default:  final_res = '0;
      endcase
   end

   // Datapath registers: load at accept, iterate while busy, publish result and zero flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result   <= '0;
         zero     <= 1'b1;
         op_r     <= '0;
         count    <= '0;
         acc      <= '0;
         quo      <= '0;
         mcand    <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
      end else if (accept) begin
         op_r  <= op;
         count <= '0;
         if (iter_op) begin
            acc      <= '0;
            quo      <= a_mag;
            mcand    <= b_mag;
            neg_q    <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r    <= signed_div && a[WIDTH-1];
            div_zero <= (b == '0);
         end else begin
            result <= single_res;
            zero   <= (single_res == '0);
         end
      end else if (state == BUSY) begin
         acc   <= acc_next;
         quo   <= quo_next;
         count <= count + {{(SHW-1){1'b0}}, 1'b1};
         if (last_iter) begin
            result <= final_res;
            zero   <= (final_res == '0);
         end
      end
   end

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: randomized and directed checks of iter_alu at WIDTH=32
// against an arithmetic reference model.
module tb_iter_alu;

   localparam int W = 32;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          out_valid;
   logic [W-1:0]  result;
   logic          zero;

   int n_cmp = 0;
   int n_bad = 0;

   iter_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .result    (result),
      .zero      (zero)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Absolute time bound so a stuck design still ends the run.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: run did not complete, got timeout, wanted finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model straight from the opcode definitions.
   function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      longint      sx;
      longint      sy;
      logic [31:0] r;
      p  = {32'd0, x} * {32'd0, y};
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r  = 32'd0;
      case (o)
         4'd0:  r = x & y;
         4'd1:  r = x | y;
         4'd2:  r = x + y;
         4'd3:  r = x ^ y;
         4'd4:  r = x - y;
         4'd5:  r = ~x;
         4'd6:  r = x << y[4:0];
         4'd7:  r = x >> y[4:0];
         4'd8:  r = $signed(x) >>> y[4:0];
         4'd9:  r = p[31:0];
         4'd10: r = p[63:32];
         4'd11: r = (y == 0) ? 32'hFFFFFFFF : x / y;
         4'd12: r = (y == 0) ? x : x % y;
         4'd13: r = (y == 0) ? 32'hFFFFFFFF : 32'(sx / sy);
         4'd14: r = (y == 0) ? x : 32'(sx % sy);
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0: v = 32'h00000000;
         1: v = 32'hFFFFFFFF;
         2: v = 32'h80000000;
         3: v = 32'($urandom_range(0, 40));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Drive one request, scramble inputs after accept, wait (bounded) for out_valid.
   task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic got, output logic [31:0] res, output logic zr,
                        output int lat, output int busy_lo);
      int guard;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; op = 4'($urandom);
      lat = 1;
      busy_lo = 0;
      while (!out_valid && lat < 100) begin
         if (!in_ready) busy_lo++;
         @(posedge clk); #1;
         lat++;
      end
      got = out_valid;
      res = result;
      zr  = zero;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; op = 4'd0; a = '0; b = '0;
      #3;
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL reset_state: got rdy=%b ov=%b res=%h z=%b, wanted rdy=0 ov=0 res=0 z=1",
                  in_ready, out_valid, result, zero);
      end
      in_valid = 1'b1; op = 4'd2; a = 32'd5; b = 32'd7;
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL ready_after_reset: got %b, wanted 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || result !== 32'd12 || zero !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL first_add: got ov=%b res=%0d z=%b, wanted ov=1 res=12 z=0", out_valid, result, zero);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || result !== 32'd12) begin
         n_bad++;
         $display("[TB] FAIL first_add_hold: got ov=%b res=%0d, wanted ov=0 res=12", out_valid, result);
      end
   endtask

   task automatic test_directed();
      logic [3:0]  ops [10] = '{4'd4, 4'd8, 4'd9, 4'd10, 4'd13, 4'd14, 4'd11, 4'd13, 4'd14, 4'd15};
      logic [31:0] as  [10] = '{32'd9, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, -32'sd7, -32'sd7,
                                32'd5, 32'h80000000, 32'h80000000, 32'h1234};
      logic [31:0] bs  [10] = '{32'd9, 32'h21, 32'd2, 32'd2, 32'd2, 32'd2,
                                32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5678};
      logic [31:0] ex  [10] = '{32'd0, 32'hC0000000, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'h80000000, 32'd0, 32'd0};
      logic got; logic [31:0] res; logic zr; int lat; int blo; int wl; int wb;
      for (int i = 0; i < 10; i++) begin
         issue(ops[i], as[i], bs[i], got, res, zr, lat, blo);
         wl = (ops[i] >= 4'd9 && ops[i] <= 4'd14) ? W + 1 : 1;
         wb = (wl == 1) ? 0 : W;
         n_cmp++;
         if (got !== 1'b1 || res !== ex[i] || zr !== (ex[i] == 0)) begin
            n_bad++;
            $display("[TB] FAIL directed_%0d op=%0d: got ov=%b res=%h z=%b, wanted ov=1 res=%h z=%b",
                     i, ops[i], got, res, zr, ex[i], (ex[i] == 0));
         end
         n_cmp++;
         if (lat != wl || blo != wb) begin
            n_bad++;
            $display("[TB] FAIL directed_lat_%0d: got lat=%0d busy=%0d, wanted lat=%0d busy=%0d",
                     i, lat, blo, wl, wb);
         end
      end
   endtask

   task automatic test_random();
      logic got; logic [31:0] res; logic zr; int lat; int blo;
      logic [3:0] o; logic [31:0] x; logic [31:0] y; logic [31:0] ex; int wl;
      for (int i = 0; i < 60; i++) begin
         o = 4'($urandom_range(0, 15));
         x = pick();
         y = pick();
         ex = model(o, x, y);
         wl = (o >= 4'd9 && o <= 4'd14) ? W + 1 : 1;
         issue(o, x, y, got, res, zr, lat, blo);
         n_cmp++;
         if (got !== 1'b1 || res !== ex || zr !== (ex == 0) || lat != wl) begin
            n_bad++;
            $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: got ov=%b res=%h z=%b lat=%0d, wanted res=%h z=%b lat=%0d",
                     i, o, x, y, got, res, zr, lat, ex, (ex == 0), wl);
         end
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid !== 1'b0 || result !== ex) begin
            n_bad++;
            $display("[TB] FAIL random_hold_%0d: got ov=%b res=%h, wanted ov=0 res=%h", i, out_valid, result, ex);
         end
      end
   endtask

   task automatic test_reset_midop();
      logic got; logic [31:0] res; logic zr; int lat; int blo; int seen;
      op = 4'd11; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || in_ready !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL midop_reset: got ov=%b res=%h z=%b rdy=%b, wanted ov=0 res=0 z=1 rdy=0",
                  out_valid, result, zero, in_ready);
      end
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL midop_release: got rdy=%b ov=%b res=%h z=%b, wanted rdy=1 ov=0 res=0 z=1",
                  in_ready, out_valid, result, zero);
      end
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_bad++;
         $display("[TB] FAIL midop_discard: got %0d out_valid cycles, wanted 0", seen);
      end
      issue(4'd2, 32'd1, 32'd1, got, res, zr, lat, blo);
      n_cmp++;
      if (got !== 1'b1 || res !== 32'd2 || lat != 1) begin
         n_bad++;
         $display("[TB] FAIL midop_next_add: got ov=%b res=%0d lat=%0d, wanted ov=1 res=2 lat=1", got, res, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic got; logic [31:0] res; logic zr; int lat; int blo; logic rdy;
      issue(4'd9, 32'd12345, 32'd678, got, res, zr, lat, blo);
      rdy = in_ready;
      op = 4'd2; a = 32'd3; b = 32'd4; in_valid = 1'b1;
      n_cmp++;
      if (got !== 1'b1 || res !== 32'd8369910 || rdy !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL b2b_mul: got ov=%b res=%0d rdy=%b, wanted ov=1 res=8369910 rdy=1", got, res, rdy);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || result !== 32'd7) begin
         n_bad++;
         $display("[TB] FAIL b2b_add: got ov=%b res=%0d, wanted ov=1 res=7", out_valid, result);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL b2b_idle: got ov=%b, wanted 0", out_valid);
      end
   endtask

   task automatic test_busy_ignore();
      int bad;
      bad = 0;
      op = 4'd13; a = 32'd100; b = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
         in_valid = ((c % 3) == 0) && (c < 30);
         op = 4'd2; a = 32'd1; b = 32'd1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("[TB] FAIL busy_handshake: got %0d bad busy cycles, wanted 0", bad);
      end
      n_cmp++;
      if (out_valid !== 1'b1 || result !== 32'd14) begin
         n_bad++;
         $display("[TB] FAIL busy_result: got ov=%b res=%0d, wanted ov=1 res=14", out_valid, result);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || result !== 32'd14) begin
         n_bad++;
         $display("[TB] FAIL busy_after: got ov=%b res=%0d, wanted ov=0 res=14", out_valid, result);
      end
   endtask

   // Scenario sequence followed by the summary.
   initial begin
      test_reset();
      test_directed();
      test_random();
      test_reset_midop();
      test_back_to_back();
      test_busy_ignore();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
